mix_columns_iter: RTL

Iterative forward AES MixColumns unit for the encryption datapath: the forward-direction counterpart of the decryption InvMixColumns helper. It accepts one 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock using the matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02} over GF(2^8) mod x^8+x^4+x^3+x+1. It then presents the result on an output handshake. A bypass flag passes the state through unchanged for the final AES round, which omits MixColumns.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/mix_column_word.sv | 24 ++
 rtl/mix_columns_iter.sv | 87 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers and MixColumns FSM encodings
package aes_pkg;

    // Low byte of the AES field polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] AES_POLY = 8'h1b;

    // Iterative MixColumns FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Multiply by x (02) in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by x+1 (03) in GF(2^8)
    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational forward MixColumns on one 32-bit column
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] column,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = column[31:24];
    assign a1 = column[23:16];
    assign a2 = column[15:8];
    assign a3 = column[7:0];

    // Circulant matrix rows {02 03 01 01} rotated right per output byte
    always_comb begin
        mixed[31:24] = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        mixed[23:16] = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        mixed[15:8]  = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        mixed[7:0]   = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative one-column-per-clock AES MixColumns with bypass
module mix_columns_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    logic [1:0]   state;
    logic [1:0]   col;
    logic [127:0] work;
    logic [31:0]  column;
    logic [31:0]  mixed;
    logic [127:0] work_wb;

    // Handshake flags come straight from the registered FSM state
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_state = work;

    // Select the column currently being transformed
    always_comb begin
        column = work[127:96];
        case (col)
            2'd0:    column = work[127:96];
            2'd1:    column = work[95:64];
            2'd2:    column = work[63:32];
            default: column = work[31:0];
        endcase
    end

    mix_column_word u_mix (
        .column (column),
        .mixed  (mixed)
    );

    // Write the mixed column back into its slot, leaving the others intact
    always_comb begin
        work_wb = work;
        case (col)
            2'd0:    work_wb[127:96] = mixed;
            2'd1:    work_wb[95:64]  = mixed;
            2'd2:    work_wb[63:32]  = mixed;
            default: work_wb[31:0]   = mixed;
        endcase
    end

    // FSM, column counter and working register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= 2'd0;
            work  <= 128'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        col   <= 2'd0;
                        state <= in_last ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work <= work_wb;
                    col  <= col + 2'd1;
                    if (col == 2'd3) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
